// File: rtl/output_argmax_classifier.sv
// rtl/output_argmax_classifier.sv - Two-score argmax with valid/ack handshake; margin output under CLASSIFIER_MARGIN_EN
// Scores may arrive on different cycles; the decision is held until acknowledged.
module output_argmax_classifier #(
    parameter int SCORE_W   = 17,
    parameter bit TIE_CLASS = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [SCORE_W-1:0] score0,
    input  logic                      score0_ready,
    input  logic signed [SCORE_W-1:0] score1,
    input  logic                      score1_ready,
    input  logic                      class_ack,
    output logic                      class_id,
    output logic                      class_valid,
`ifdef CLASSIFIER_MARGIN_EN
    output logic        [SCORE_W:0]   margin,
`endif
    output logic                      overrun
);

    typedef enum logic [1:0] {S_IDLE, S_PARTIAL, S_DECIDE, S_HOLD} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic signed [SCORE_W-1:0] r_s0;
    logic signed [SCORE_W-1:0] r_s1;
    logic                      r_got0;
    logic                      r_got1;
    logic                      r_class_id;
    logic                      r_class_valid;
    logic                      r_overrun;
    logic                      w_cap0;
    logic                      w_cap1;
    logic                      w_clr_got;
    logic                      w_set_ovr;
    logic                      w_decide;
    logic                      w_valid_set;
    logic                      w_valid_clr;
    logic                      w_cls;

    always_comb begin
        w_next      = r_state;
        w_cap0      = 1'b0;
        w_cap1      = 1'b0;
        w_clr_got   = 1'b0;
        w_set_ovr   = 1'b0;
        w_decide    = 1'b0;
        w_valid_set = 1'b0;
        w_valid_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cap0 = score0_ready;
                w_cap1 = score1_ready;
                if (score0_ready && score1_ready)     w_next = S_DECIDE;
                else if (score0_ready || score1_ready) w_next = S_PARTIAL;
            end
            S_PARTIAL: begin
                w_cap0    = score0_ready;
                w_cap1    = score1_ready;
                w_set_ovr = (score0_ready && r_got0) || (score1_ready && r_got1);
                if ((r_got0 || score0_ready) && (r_got1 || score1_ready)) w_next = S_DECIDE;
            end
            S_DECIDE: begin
                w_decide  = 1'b1;
                w_set_ovr = score0_ready || score1_ready;
                w_next    = S_HOLD;
            end
            S_HOLD: begin
                // First HOLD cycle only raises class_valid; ack is meaningless until then.
                if (!r_class_valid) begin
                    w_valid_set = 1'b1;
                    w_set_ovr   = score0_ready || score1_ready;
                end else if (class_ack) begin
                    w_valid_clr = 1'b1;
                    w_clr_got   = 1'b1;
                    w_cap0      = score0_ready;
                    w_cap1      = score1_ready;
                    if (score0_ready && score1_ready)      w_next = S_DECIDE;
                    else if (score0_ready || score1_ready) w_next = S_PARTIAL;
                    else                                   w_next = S_IDLE;
                end else begin
                    w_set_ovr = score0_ready || score1_ready;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cls = TIE_CLASS;
        if (r_s1 > r_s0)      w_cls = 1'b1;
        else if (r_s0 > r_s1) w_cls = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_s0          <= '0;
            r_s1          <= '0;
            r_got0        <= 1'b0;
            r_got1        <= 1'b0;
            r_class_id    <= 1'b0;
            r_class_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_cap0) r_s0 <= score0;
            if (w_cap1) r_s1 <= score1;
            if (w_clr_got) begin
                r_got0 <= w_cap0;
                r_got1 <= w_cap1;
            end else begin
                r_got0 <= r_got0 | w_cap0;
                r_got1 <= r_got1 | w_cap1;
            end
            if (w_decide)         r_class_id    <= w_cls;
            if (w_valid_set)      r_class_valid <= 1'b1;
            else if (w_valid_clr) r_class_valid <= 1'b0;
            if (w_set_ovr)        r_overrun     <= 1'b1;
        end
    end

`ifdef CLASSIFIER_MARGIN_EN
    // Sign-extend before subtracting so the extreme difference cannot overflow.
    logic signed [SCORE_W:0] w_diff;
    logic        [SCORE_W:0] w_abs;
    logic        [SCORE_W:0] r_margin;

    assign w_diff = {r_s0[SCORE_W-1], r_s0} - {r_s1[SCORE_W-1], r_s1};
    assign w_abs  = w_diff[SCORE_W] ? -w_diff : w_diff;

    always_ff @(posedge clk) begin
        if (rst)           r_margin <= '0;
        else if (w_decide) r_margin <= w_abs;
    end

    assign margin = r_margin;
`endif

    assign class_id    = r_class_id;
    assign class_valid = r_class_valid;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_output_argmax_classifier.sv
// tb/tb_output_argmax_classifier.sv - Directed self-checking bench for output_argmax_classifier (margin checks under CLASSIFIER_MARGIN_EN)
module tb_output_argmax_classifier;

    localparam int SCORE_W = 17;

    logic                      clk = 1'b0;
    logic                      rst;
    logic signed [SCORE_W-1:0] score0;
    logic                      score0_ready;
    logic signed [SCORE_W-1:0] score1;
    logic                      score1_ready;
    logic                      class_ack;
    logic                      class_id_a;
    logic                      class_valid_a;
    logic                      overrun_a;
    logic                      class_id_b;
    logic                      class_valid_b;
    logic                      overrun_b;
`ifdef CLASSIFIER_MARGIN_EN
    logic        [SCORE_W:0]   margin_a;
    logic        [SCORE_W:0]   margin_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    output_argmax_classifier #(.SCORE_W(SCORE_W), .TIE_CLASS(1'b0)) dut_a (
        .clk(clk), .rst(rst),
        .score0(score0), .score0_ready(score0_ready),
        .score1(score1), .score1_ready(score1_ready),
        .class_ack(class_ack),
        .class_id(class_id_a), .class_valid(class_valid_a),
`ifdef CLASSIFIER_MARGIN_EN
        .margin(margin_a),
`endif
        .overrun(overrun_a)
    );

    output_argmax_classifier #(.SCORE_W(SCORE_W), .TIE_CLASS(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .score0(score0), .score0_ready(score0_ready),
        .score1(score1), .score1_ready(score1_ready),
        .class_ack(class_ack),
        .class_id(class_id_b), .class_valid(class_valid_b),
`ifdef CLASSIFIER_MARGIN_EN
        .margin(margin_b),
`endif
        .overrun(overrun_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        score0_ready = 1'b0;
        score1_ready = 1'b0;
        class_ack    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        score0 = '0;
        score1 = '0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (class_valid_a !== 1'b0 || class_id_a !== 1'b0 || overrun_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a valid/id/ovr got %b%b%b want 000", class_valid_a, class_id_a, overrun_a);
        end
        checks++;
        if (class_valid_b !== 1'b0 || class_id_b !== 1'b0 || overrun_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b valid/id/ovr got %b%b%b want 000", class_valid_b, class_id_b, overrun_b);
        end
`ifdef CLASSIFIER_MARGIN_EN
        checks++;
        if (margin_a !== '0) begin
            errors++;
            $display("FAIL reset_margin got %0d want 0", margin_a);
        end
`endif
    endtask

    task automatic test_same_cycle;
        score0 = 17'sd100;
        score1 = -17'sd50;
        score0_ready = 1'b1;
        score1_ready = 1'b1;
        tick();
        score0_ready = 1'b0;
        score1_ready = 1'b0;
        class_ack = 1'b1;
        checks++;
        if (class_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL same_lat1 valid got %b want 0", class_valid_a);
        end
        tick();
        checks++;
        if (class_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL same_lat2 valid got %b want 0", class_valid_a);
        end
        tick();
        checks++;
        if (class_valid_a !== 1'b1 || class_id_a !== 1'b0) begin
            errors++;
            $display("FAIL same_decide valid/id got %b/%b want 1/0", class_valid_a, class_id_a);
        end
`ifdef CLASSIFIER_MARGIN_EN
        checks++;
        if (margin_a !== 18'd150) begin
            errors++;
            $display("FAIL same_margin got %0d want 150", margin_a);
        end
`endif
        tick();
        class_ack = 1'b0;
        checks++;
        if (class_valid_a !== 1'b0 || overrun_a !== 1'b0) begin
            errors++;
            $display("FAIL same_ack valid/ovr got %b/%b want 0/0", class_valid_a, overrun_a);
        end
    endtask

    task automatic test_partial;
        score1 = -17'sd3;
        score1_ready = 1'b1;
        tick();
        score1_ready = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (class_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL partial_wait valid got %b want 0", class_valid_a);
        end
        score0 = -17'sd7;
        score0_ready = 1'b1;
        tick();
        score0_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (class_valid_a !== 1'b1 || class_id_a !== 1'b1) begin
            errors++;
            $display("FAIL partial_decide valid/id got %b/%b want 1/1", class_valid_a, class_id_a);
        end
`ifdef CLASSIFIER_MARGIN_EN
        checks++;
        if (margin_a !== 18'd4) begin
            errors++;
            $display("FAIL partial_margin got %0d want 4", margin_a);
        end
`endif
        class_ack = 1'b1;
        tick();
        class_ack = 1'b0;
    endtask

    task automatic test_tie;
        score0 = 17'sd65535;
        score1 = 17'sd65535;
        score0_ready = 1'b1;
        score1_ready = 1'b1;
        tick();
        score0_ready = 1'b0;
        score1_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (class_valid_a !== 1'b1 || class_id_a !== 1'b0) begin
            errors++;
            $display("FAIL tie0 valid/id got %b/%b want 1/0", class_valid_a, class_id_a);
        end
        checks++;
        if (class_valid_b !== 1'b1 || class_id_b !== 1'b1) begin
            errors++;
            $display("FAIL tie1 valid/id got %b/%b want 1/1", class_valid_b, class_id_b);
        end
`ifdef CLASSIFIER_MARGIN_EN
        checks++;
        if (margin_a !== 18'd0 || margin_b !== 18'd0) begin
            errors++;
            $display("FAIL tie_margin got %0d/%0d want 0/0", margin_a, margin_b);
        end
`endif
        class_ack = 1'b1;
        tick();
        class_ack = 1'b0;
    endtask

    task automatic test_extremes;
        score0 = -17'sd65536;
        score1 = 17'sd65535;
        score0_ready = 1'b1;
        score1_ready = 1'b1;
        tick();
        score0_ready = 1'b0;
        score1_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (class_valid_a !== 1'b1 || class_id_a !== 1'b1 || overrun_a !== 1'b0) begin
            errors++;
            $display("FAIL extreme valid/id/ovr got %b/%b/%b want 1/1/0", class_valid_a, class_id_a, overrun_a);
        end
`ifdef CLASSIFIER_MARGIN_EN
        checks++;
        if (margin_a !== 18'd131071) begin
            errors++;
            $display("FAIL extreme_margin got %0d want 131071", margin_a);
        end
`endif
        class_ack = 1'b1;
        tick();
        class_ack = 1'b0;
    endtask

    task automatic test_hold_overrun;
        score0 = 17'sd10;
        score1 = 17'sd20;
        score0_ready = 1'b1;
        score1_ready = 1'b1;
        tick();
        score0_ready = 1'b0;
        score1_ready = 1'b0;
        tick();
        tick();
        score0 = 17'sd500;
        score0_ready = 1'b1;
        tick();
        score0_ready = 1'b0;
        checks++;
        if (overrun_a !== 1'b1 || class_valid_a !== 1'b1 || class_id_a !== 1'b1) begin
            errors++;
            $display("FAIL hold_drop ovr/valid/id got %b/%b/%b want 1/1/1", overrun_a, class_valid_a, class_id_a);
        end
        score0 = 17'sd30;
        score1 = 17'sd5;
        score0_ready = 1'b1;
        score1_ready = 1'b1;
        class_ack = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (class_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ack valid got %b want 0", class_valid_a);
        end
        tick();
        tick();
        checks++;
        if (class_valid_a !== 1'b1 || class_id_a !== 1'b0 || overrun_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_decide valid/id/ovr got %b/%b/%b want 1/0/1", class_valid_a, class_id_a, overrun_a);
        end
`ifdef CLASSIFIER_MARGIN_EN
        checks++;
        if (margin_a !== 18'd25) begin
            errors++;
            $display("FAIL b2b_margin got %0d want 25", margin_a);
        end
`endif
    endtask

    task automatic test_reset_mid;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (class_valid_a !== 1'b0 || class_id_a !== 1'b0 || overrun_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold valid/id/ovr got %b/%b/%b want 0/0/0", class_valid_a, class_id_a, overrun_a);
        end
`ifdef CLASSIFIER_MARGIN_EN
        checks++;
        if (margin_a !== '0) begin
            errors++;
            $display("FAIL rst_hold_margin got %0d want 0", margin_a);
        end
`endif
        score0 = 17'sd7;
        score0_ready = 1'b1;
        tick();
        score0_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        score1 = 17'sd9;
        score1_ready = 1'b1;
        tick();
        score1_ready = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (class_valid_a !== 1'b0 || overrun_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_partial valid/ovr got %b/%b want 0/0", class_valid_a, overrun_a);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_partial_repeat;
        score0 = 17'sd1;
        score0_ready = 1'b1;
        tick();
        score0 = -17'sd20;
        tick();
        score0_ready = 1'b0;
        checks++;
        if (overrun_a !== 1'b1 || class_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL repeat_ovr ovr/valid got %b/%b want 1/0", overrun_a, class_valid_a);
        end
        score1 = -17'sd10;
        score1_ready = 1'b1;
        tick();
        score1_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (class_valid_a !== 1'b1 || class_id_a !== 1'b1) begin
            errors++;
            $display("FAIL repeat_decide valid/id got %b/%b want 1/1", class_valid_a, class_id_a);
        end
`ifdef CLASSIFIER_MARGIN_EN
        checks++;
        if (margin_a !== 18'd10) begin
            errors++;
            $display("FAIL repeat_margin got %0d want 10", margin_a);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_partial();
        test_tie();
        test_extremes();
        test_hold_overrun();
        test_reset_mid();
        test_partial_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
